// File: rtl/nf10_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nf10_sched_pkg: shared types and helpers for the DWRR port scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nf10_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: rotated priority encoder, first request at or after ptr     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0] cand;

  // Walk from the far end back to ptr so the nearest request is written last.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (W + 1)'(k);
      if (cand >= (W + 1)'(N)) cand = cand - (W + 1)'(N);
      if (req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nf10_dwrr_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nf10_dwrr_port_scheduler: packet-granular weighted RR AXIS arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nf10_dwrr_port_scheduler
  import nf10_sched_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_NUM_QUEUES       = 5,
  parameter int C_WEIGHT_WIDTH       = 8,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                                            axi_aclk,
  input  logic                                            axi_rst,
  input  logic                                            sw_rst,
  input  logic [C_S_NUM_QUEUES*C_WEIGHT_WIDTH-1:0]        weights_grp,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                            m_axis_tvalid,
  output logic                                            m_axis_tlast,
  input  logic                                            m_axis_tready,

  input  logic [C_S_NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_grp,
  input  logic [C_S_NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_grp,
  input  logic [C_S_NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser_grp,
  input  logic [C_S_NUM_QUEUES-1:0]                       s_axis_tvalid_grp,
  input  logic [C_S_NUM_QUEUES-1:0]                       s_axis_tlast_grp,
  output logic [C_S_NUM_QUEUES-1:0]                       s_axis_tready_grp,

  output logic [clog2(C_S_NUM_QUEUES)-1:0]                grant_idx,
  output logic                                            busy,
  output logic [C_S_NUM_QUEUES*C_CNT_WIDTH-1:0]           pkt_cnt_grp
);

  localparam int N      = C_S_NUM_QUEUES;
  localparam int QIDX_W = clog2(C_S_NUM_QUEUES);
  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int WW     = C_WEIGHT_WIDTH;
  localparam int CW     = C_CNT_WIDTH;

  state_t              state;
  state_t              state_nxt;
  logic [QIDX_W-1:0]   cur;
  logic [QIDX_W-1:0]   ptr;
  logic [WW-1:0]       burst_left;

  logic [DW-1:0]       s_data   [N];
  logic [SW-1:0]       s_strb   [N];
  logic [UW-1:0]       s_user   [N];
  logic [WW-1:0]       weight   [N];
  logic [N-1:0]        req;

  logic                pick_found;
  logic [QIDX_W-1:0]   pick_idx;
  logic                last_hs;

  genvar g;
  for (g = 0; g < N; g++) begin : g_unpack
    assign s_data[g] = s_axis_tdata_grp[g*DW +: DW];
    assign s_strb[g] = s_axis_tstrb_grp[g*SW +: SW];
    assign s_user[g] = s_axis_tuser_grp[g*UW +: UW];
    assign weight[g] = weights_grp[g*WW +: WW];
    // A zero-weight queue is invisible to the arbiter.
    assign req[g]    = s_axis_tvalid_grp[g] && (weight[g] != '0);
  end

  rr_pick #(
    .N (N),
    .W (QIDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign last_hs = (state == SEND) && s_axis_tvalid_grp[cur] &&
                   s_axis_tlast_grp[cur] && m_axis_tready;

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = SEND;
      SEND:    if (last_hs)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tstrb      = '0;
    m_axis_tuser      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    s_axis_tready_grp = '0;
    if (state == SEND) begin
      m_axis_tdata           = s_data[cur];
      m_axis_tstrb           = s_strb[cur];
      m_axis_tuser           = s_user[cur];
      m_axis_tvalid          = s_axis_tvalid_grp[cur];
      m_axis_tlast           = s_axis_tlast_grp[cur];
      s_axis_tready_grp[cur] = m_axis_tready;
    end
  end

  assign busy      = (state == SEND);
  assign grant_idx = cur;

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      cur        <= '0;
      ptr        <= '0;
      burst_left <= '0;
    end else if (sw_rst) begin
      cur        <= '0;
      ptr        <= '0;
      burst_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            cur <= pick_idx;
            // Re-granting the same queue mid-burst keeps its remaining quota.
            if (!((pick_idx == cur) && (burst_left != '0))) begin
              burst_left <= weight[pick_idx];
            end
          end
        end
        SEND: begin
          if (last_hs) begin
            if ((burst_left > WW'(1)) && (weight[cur] != '0)) begin
              burst_left <= burst_left - 1'b1;
              ptr        <= cur;
            end else begin
              burst_left <= '0;
              ptr        <= (cur == QIDX_W'(N - 1)) ? '0 : cur + 1'b1;
            end
          end
        end
        default: begin
          burst_left <= '0;
        end
      endcase
    end
  end

  for (g = 0; g < N; g++) begin : g_cnt
    logic [CW-1:0] cnt_q;
    always_ff @(posedge axi_aclk or posedge axi_rst) begin
      if (axi_rst) begin
        cnt_q <= '0;
      end else if (sw_rst) begin
        cnt_q <= '0;
      end else if (last_hs && (cur == QIDX_W'(g))) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign pkt_cnt_grp[g*CW +: CW] = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_nf10_dwrr_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nf10_dwrr_port_scheduler: directed bench for the DWRR scheduler   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_nf10_dwrr_port_scheduler;

  localparam int N  = 5;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int WW = 8;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sw_rst;
  logic [N*WW-1:0]      weights_grp;
  logic [DW-1:0]        m_axis_tdata;
  logic [DW/8-1:0]      m_axis_tstrb;
  logic [UW-1:0]        m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
  logic [N*DW-1:0]      s_axis_tdata_grp;
  logic [N*DW/8-1:0]    s_axis_tstrb_grp;
  logic [N*UW-1:0]      s_axis_tuser_grp;
  logic [N-1:0]         s_axis_tvalid_grp;
  logic [N-1:0]         s_axis_tlast_grp;
  logic [N-1:0]         s_axis_tready_grp;
  logic [2:0]           grant_idx;
  logic                 busy;
  logic [N*CW-1:0]      pkt_cnt_grp;

  int checks = 0;
  int errors = 0;
  int en   [N];
  int len  [N];
  int beat [N];
  int pkt  [N];
  int log_q[$];
  bit seen2;

  always #5 clk = ~clk;

  nf10_dwrr_port_scheduler #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .C_S_NUM_QUEUES       (N),
    .C_WEIGHT_WIDTH       (WW),
    .C_CNT_WIDTH          (CW)
  ) dut (
    .axi_aclk          (clk),
    .axi_rst           (rst),
    .sw_rst            (sw_rst),
    .weights_grp       (weights_grp),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tstrb      (m_axis_tstrb),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .s_axis_tdata_grp  (s_axis_tdata_grp),
    .s_axis_tstrb_grp  (s_axis_tstrb_grp),
    .s_axis_tuser_grp  (s_axis_tuser_grp),
    .s_axis_tvalid_grp (s_axis_tvalid_grp),
    .s_axis_tlast_grp  (s_axis_tlast_grp),
    .s_axis_tready_grp (s_axis_tready_grp),
    .grant_idx         (grant_idx),
    .busy              (busy),
    .pkt_cnt_grp       (pkt_cnt_grp)
  );

  function automatic logic [63:0] mkdata(input int q, input int p, input int b);
    return {8'(q), 24'(p), 32'(b)};
  endfunction

  function automatic logic [CW-1:0] cnt(input int q);
    return pkt_cnt_grp[q*CW +: CW];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid_grp[i]           = (en[i] != 0);
      s_axis_tdata_grp[i*DW +: DW]   = mkdata(i, pkt[i], beat[i]);
      s_axis_tstrb_grp[i*8 +: 8]     = 8'hFF;
      s_axis_tuser_grp[i*UW +: UW]   = 16'(i * 256 + beat[i]);
      s_axis_tlast_grp[i]            = (beat[i] == len[i] - 1);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      en[i]   = 0;
      len[i]  = 1;
      beat[i] = 0;
      pkt[i]  = 0;
    end
    drive();
  endtask

  // Sample at the falling edge, clock, then advance each source that handshook.
  task automatic tick();
    bit hs  [N];
    bit lst [N];
    #4;
    for (int i = 0; i < N; i++) begin
      hs[i]  = (en[i] != 0) && s_axis_tready_grp[i];
      lst[i] = s_axis_tlast_grp[i];
      if (hs[i] && lst[i]) log_q.push_back(i);
    end
    if (s_axis_tready_grp[2]) seen2 = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (lst[i]) begin
          beat[i] = 0;
          pkt[i]++;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic check_log(input string tag, input string exp);
    check({tag, "_len"}, 64'(log_q.size()), 64'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      if (i < log_q.size()) check(tag, 64'(log_q[i]), 64'(exp[i] - 8'h30));
    end
  endtask

  task automatic restart();
    clear_sources();
    m_axis_tready = 1'b0;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    clear_sources();
    log_q.delete();
    seen2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    sw_rst        = 1'b0;
    m_axis_tready = 1'b0;
    weights_grp   = '0;
    seen2         = 1'b0;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_tready_grp), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_cnt", 64'(pkt_cnt_grp), 64'd0);
    rst = 1'b0;

    // Equal weights, single-beat packets: strict rotation, 2 cycles each.
    weights_grp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < N; i++) en[i] = 1;
    m_axis_tready = 1'b1;
    drive();
    repeat (40) tick();
    check_log("t1_order", "01234012340123401234");
    for (int q = 0; q < N; q++) check("t1_cnt", 64'(cnt(q)), 64'd4);

    // q0 weight 3, 2-beat packets.
    restart();
    weights_grp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd3};
    for (int i = 0; i < N; i++) begin
      en[i]  = 1;
      len[i] = 2;
    end
    m_axis_tready = 1'b1;
    drive();
    tick();
    tick();
    #1;
    check("t2_tdata", m_axis_tdata, mkdata(0, 0, 1));
    check("t2_tuser", 64'(m_axis_tuser), 64'd1);
    check("t2_tlast", 64'(m_axis_tlast), 64'd1);
    tick();
    #1;
    check("t2_idle_grant", 64'(grant_idx), 64'd0);
    check("t2_idle_busy", 64'(busy), 64'd0);
    repeat (21) tick();
    check_log("t2_order", "00012340");
    check("t2_cnt0", 64'(cnt(0)), 64'd4);

    // q2 disabled by zero weight.
    restart();
    weights_grp = {8'd1, 8'd1, 8'd0, 8'd1, 8'd1};
    for (int i = 0; i < N; i++) en[i] = 1;
    m_axis_tready = 1'b1;
    drive();
    repeat (16) tick();
    check_log("t3_order", "01340134");
    check("t3_tready2", 64'(seen2), 64'd0);
    check("t3_cnt2", 64'(cnt(2)), 64'd0);
    check("t3_cnt3", 64'(cnt(3)), 64'd2);

    // Back-pressure during a 4-beat packet on q1 while q3 waits.
    restart();
    weights_grp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    len[1] = 4;
    en[1]  = 1;
    m_axis_tready = 1'b1;
    drive();
    tick();
    en[3] = 1;
    drive();
    tick();
    tick();
    m_axis_tready = 1'b0;
    repeat (3) tick();
    #1;
    check("t4_hold_data", m_axis_tdata, mkdata(1, 0, 2));
    check("t4_hold_grant", 64'(grant_idx), 64'd1);
    check("t4_hold_valid", 64'(m_axis_tvalid), 64'd1);
    check("t4_hold_tready", 64'(s_axis_tready_grp), 64'd0);
    m_axis_tready = 1'b1;
    tick();
    tick();
    #1;
    check("t4_gap_busy", 64'(busy), 64'd0);
    check("t4_gap_tready", 64'(s_axis_tready_grp), 64'd0);
    tick();
    #1;
    check("t4_q3_grant", 64'(grant_idx), 64'd3);
    check("t4_q3_data", m_axis_tdata, mkdata(3, 0, 0));
    tick();
    check_log("t4_order", "13");

    // Counter wrap at 2^C_CNT_WIDTH.
    restart();
    en[0] = 1;
    m_axis_tready = 1'b1;
    drive();
    repeat (30) tick();
    check("t5_cnt15", 64'(cnt(0)), 64'd15);
    repeat (2) tick();
    check("t5_wrap", 64'(cnt(0)), 64'd0);

    // Asynchronous reset in the middle of a packet on q2.
    restart();
    len[2] = 4;
    en[2]  = 1;
    m_axis_tready = 1'b1;
    drive();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_tready", 64'(s_axis_tready_grp), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_grant", 64'(grant_idx), 64'd0);
    @(posedge clk);
    #1;
    clear_sources();
    for (int i = 1; i < N; i++) en[i] = 1;
    drive();
    log_q.delete();
    rst = 1'b0;
    tick();
    tick();
    check_log("t6_next", "1");

    // Soft reset coinciding with a tlast handshake.
    restart();
    en[0] = 1;
    m_axis_tready = 1'b1;
    drive();
    tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    en[0]  = 0;
    drive();
    #1;
    check("t7_hs_seen", 64'(log_q.size()), 64'd1);
    check("t7_cnt", 64'(cnt(0)), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
